// File: rtl/input_pixel_streamer.sv
// Binarises a frame of 8-bit grayscale pixels into a bit buffer, then streams it to the input layer.
// Optional feature: define ACTIVE_PIXEL_COUNT_EN to add the activeCount port (set bits in the last streamed frame).
module input_pixel_streamer #(
  parameter int unsigned FRAME_PIXELS = 784,
  parameter int unsigned THRESHOLD    = 128
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pixelIn,
  input  logic       pixelInValid,
  output logic       pixelInReady,
  input  logic       readyForInputs,
  output logic       inputsInbound,
  output logic       pixelValue,
  output logic       frameDone
`ifdef ACTIVE_PIXEL_COUNT_EN
  ,
  output logic [9:0] activeCount
`endif
);

  localparam int unsigned IDX_W    = 10;
  localparam int unsigned PIX_W    = 8;
  localparam int unsigned LAST_IDX = FRAME_PIXELS - 1;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    WAIT   = 2'd1,
    STREAM = 2'd2
  } stateType;

  stateType                state;
  logic [FRAME_PIXELS-1:0] frameBuf;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        nextIdx;
  logic                    lastIdx;
  logic                    pixelBit;

  assign nextIdx  = idx + IDX_W'(1);
  assign lastIdx  = (idx == IDX_W'(LAST_IDX));
  assign pixelBit = (pixelIn >= PIX_W'(THRESHOLD));

  // Frame buffer is never cleared; every bit is rewritten before it is streamed.
  always_ff @(posedge clk) begin
    if (state == LOAD && pixelInValid) begin
      frameBuf[idx] <= pixelBit;
    end
  end

  // Control FSM; every output is a register, so no input reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= LOAD;
      idx           <= '0;
      pixelInReady  <= 1'b1;
      inputsInbound <= 1'b0;
      pixelValue    <= 1'b0;
      frameDone     <= 1'b0;
    end else begin
      frameDone <= 1'b0;
      unique case (state)
        LOAD: begin
          if (pixelInValid) begin
            if (lastIdx) begin
              state        <= WAIT;
              idx          <= '0;
              pixelInReady <= 1'b0;
            end else begin
              idx <= nextIdx;
            end
          end
        end
        WAIT: begin
          // Pixel 0 is presented in the first STREAM cycle, so prefetch it here.
          if (readyForInputs) begin
            state         <= STREAM;
            inputsInbound <= 1'b1;
            pixelValue    <= frameBuf[0];
          end
        end
        STREAM: begin
          if (lastIdx) begin
            state         <= LOAD;
            idx           <= '0;
            inputsInbound <= 1'b0;
            pixelValue    <= 1'b0;
            frameDone     <= 1'b1;
            pixelInReady  <= 1'b1;
          end else begin
            idx        <= nextIdx;
            pixelValue <= frameBuf[nextIdx];
          end
        end
        default: begin
          state         <= LOAD;
          idx           <= '0;
          pixelInReady  <= 1'b1;
          inputsInbound <= 1'b0;
          pixelValue    <= 1'b0;
        end
      endcase
    end
  end

`ifdef ACTIVE_PIXEL_COUNT_EN
  localparam int unsigned CNT_W = 10;

  logic [CNT_W-1:0] onesCount;

  // Running total of streamed ones; published only when a frame completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      onesCount   <= '0;
      activeCount <= '0;
    end else if (state == STREAM) begin
      if (lastIdx) begin
        activeCount <= onesCount + CNT_W'(pixelValue);
        onesCount   <= '0;
      end else begin
        onesCount <= onesCount + CNT_W'(pixelValue);
      end
    end
  end
`endif

endmodule

// File: tb/tb_input_pixel_streamer.sv
// Scoreboard bench: the driver queues expected frame bits as pixels are accepted; the monitor pops and compares while streaming.
module tb_input_pixel_streamer;

  localparam int unsigned FRAME_PIXELS = 784;
  localparam int unsigned THRESHOLD    = 128;
  localparam int          TIMEOUT      = 3000;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pixelIn;
  logic       pixelInValid;
  logic       pixelInReady;
  logic       readyForInputs;
  logic       inputsInbound;
  logic       pixelValue;
  logic       frameDone;
`ifdef ACTIVE_PIXEL_COUNT_EN
  logic [9:0] activeCount;
`endif

  int vectors     = 0;
  int miscompares = 0;
  bit expQ[$];
  int expOnes     = 0;
  bit monEn       = 1'b0;
  int streamed    = 0;
  bit prevInbound = 1'b0;

  input_pixel_streamer #(
    .FRAME_PIXELS(FRAME_PIXELS),
    .THRESHOLD   (THRESHOLD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pixelIn       (pixelIn),
    .pixelInValid  (pixelInValid),
    .pixelInReady  (pixelInReady),
    .readyForInputs(readyForInputs),
    .inputsInbound (inputsInbound),
    .pixelValue    (pixelValue),
    .frameDone     (frameDone)
`ifdef ACTIVE_PIXEL_COUNT_EN
    ,
    .activeCount   (activeCount)
`endif
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: each streamed bit must match the next accepted pixel; frameDone only right after a full frame.
  always @(negedge clk) begin
    bit b;
    bit expDone;
    if (monEn) begin
      if (inputsInbound) begin
        if (expQ.size() == 0) begin
          check("unexpected_stream_bit", 32'(streamed), 32'(FRAME_PIXELS));
        end else begin
          b = expQ.pop_front();
          check("stream_bit", 32'(pixelValue), 32'(b));
        end
        check("done_in_stream", 32'(frameDone), 0);
        streamed++;
      end else begin
        check("idle_pixel_value", 32'(pixelValue), 0);
        expDone = prevInbound && (streamed == FRAME_PIXELS);
        check("frame_done", 32'(frameDone), 32'(expDone));
        streamed = 0;
      end
      prevInbound = inputsInbound;
    end
  end

  // mode 0: all 200, mode 1: alternating 127/128, else random; stall gives ~50% valid duty.
  task automatic loadFrame(input int mode, input bit stall);
    logic [7:0] p;
    expOnes = 0;
    for (int i = 0; i < FRAME_PIXELS; i++) begin
      if (stall) begin
        while ($urandom_range(1) == 0) begin
          pixelInValid = 1'b0;
          pixelIn      = 8'($urandom);
          @(negedge clk);
        end
      end
      case (mode)
        0:       p = 8'd200;
        1:       p = (i % 2 == 0) ? 8'd127 : 8'd128;
        default: p = 8'($urandom_range(255));
      endcase
      check("ready_in_load", 32'(pixelInReady), 1);
      pixelIn      = p;
      pixelInValid = 1'b1;
      expQ.push_back(bit'(p >= THRESHOLD));
      if (p >= THRESHOLD) expOnes++;
      @(negedge clk);
    end
    pixelInValid = 1'b0;
    check("ready_after_load", 32'(pixelInReady), 0);
  endtask

  task automatic streamFrame(input int holdOff, input int dropAt, input int abortAt);
    int n;
    readyForInputs = 1'b0;
    for (int i = 0; i < holdOff; i++) begin
      check("wait_ready", 32'(pixelInReady), 0);
      check("wait_inbound", 32'(inputsInbound), 0);
      @(negedge clk);
    end
    readyForInputs = 1'b1;
    @(negedge clk);
    check("stream_start", 32'(inputsInbound), 1);
    n = 1;
    while (!frameDone && n < TIMEOUT) begin
      if (n == dropAt) readyForInputs = 1'b0;
      if (n == abortAt) begin
        reset          = 1'b1;
        readyForInputs = 1'b0;
        @(negedge clk);
        check("abort_inbound", 32'(inputsInbound), 0);
        check("abort_done", 32'(frameDone), 0);
        reset = 1'b0;
        expQ.delete();
        check("ready_after_abort", 32'(pixelInReady), 1);
        return;
      end
      @(negedge clk);
      n++;
    end
    check("frame_done_seen", 32'(frameDone), 1);
    check("stream_length", 32'(n - 1), 32'(FRAME_PIXELS));
    readyForInputs = 1'b0;
`ifdef ACTIVE_PIXEL_COUNT_EN
    check("active_count", 32'(activeCount), 32'(expOnes));
`endif
  endtask

  initial begin
    reset          = 1'b1;
    pixelIn        = '0;
    pixelInValid   = 1'b0;
    readyForInputs = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_ready", 32'(pixelInReady), 1);
    check("reset_inbound", 32'(inputsInbound), 0);
    check("reset_pixel_value", 32'(pixelValue), 0);
    check("reset_frame_done", 32'(frameDone), 0);
`ifdef ACTIVE_PIXEL_COUNT_EN
    check("reset_active_count", 32'(activeCount), 0);
`endif
    monEn = 1'b1;

    loadFrame(0, 1'b0);
    streamFrame(0, 0, 0);
    loadFrame(1, 1'b0);
    streamFrame(3, 0, 0);
    loadFrame(2, 1'b1);
    streamFrame(100, 300, 0);
    loadFrame(2, 1'b1);
    streamFrame(0, 0, 401);
    loadFrame(2, 1'b0);
    streamFrame(5, 50, 0);

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(expQ.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/input_pixel_streamer.md
INPUT_PIXEL_STREAMER -- requirements
Module: input_pixel_streamer

Interface
REQ-001 The block SHALL have parameters (name, default, meaning): FRAME_PIXELS, 784, pixels per frame.
REQ-002 The block SHALL have parameter THRESHOLD, 128, binarisation threshold for an 8-bit grayscale pixel.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-005 The block SHALL have port pixelIn, input, 8, grayscale pixel from the upstream source.
REQ-006 The block SHALL have port pixelInValid, input, 1, pixelIn holds a valid pixel.
REQ-007 The block SHALL have port pixelInReady, output, 1, the block accepts pixelIn this cycle.
REQ-008 The block SHALL have port readyForInputs, input, 1, the downstream input layer can take a frame.
REQ-009 The block SHALL have port inputsInbound, output, 1, pixelValue carries frame bits this cycle.
REQ-010 The block SHALL have port pixelValue, output, 1, binarised pixel, one per cycle while inputsInbound.
REQ-011 The block SHALL have port frameDone, output, 1, one-cycle pulse after the last bit is streamed.
REQ-012 With ACTIVE_PIXEL_COUNT_EN defined, the block SHALL have port activeCount, output, 10, count of set bits in the last streamed frame.

Function
REQ-013 The block SHALL implement states LOAD, WAIT, STREAM, held in a registered state variable.
REQ-014 In LOAD, pixelInReady SHALL be 1; on each cycle with pixelInValid=1, bit[idx] of a FRAME_PIXELS-bit frame buffer SHALL be written with (pixelIn >= THRESHOLD) and the 10-bit index SHALL increment.
REQ-015 An accepted pixel at index FRAME_PIXELS-1 SHALL move LOAD->WAIT and clear the index to 0.
REQ-016 Cycles with pixelInValid=0 in LOAD SHALL change nothing (stall allowed, any length).
REQ-017 In WAIT and STREAM, pixelInReady SHALL be 0.
REQ-018 In WAIT, readyForInputs=1 sampled at a rising edge SHALL move WAIT->STREAM on that edge.
REQ-019 In STREAM, inputsInbound SHALL be 1 and pixelValue SHALL equal buffer bit[idx], pixel 0 first, with no gap cycles; idx increments every cycle.
REQ-020 STREAM SHALL last exactly FRAME_PIXELS cycles; readyForInputs is ignored in STREAM (no abort, no stall).
REQ-021 On the edge ending the cycle with idx=FRAME_PIXELS-1 the block SHALL go STREAM->LOAD, clear idx, and assert frameDone for exactly the following cycle.
REQ-022 Outside STREAM, inputsInbound SHALL be 0 and pixelValue SHALL be 0.
REQ-023 The index SHALL never exceed FRAME_PIXELS-1; no wrap beyond it.
REQ-024 pixelInReady, inputsInbound, pixelValue and frameDone SHALL be driven from registers or from the state register only; no combinational path from any input to any output.
REQ-025 A new frame MAY begin loading in the cycle frameDone is high; the buffer is overwritten bit by bit.

Reset
REQ-026 reset=1 at a rising edge SHALL force state LOAD, idx 0, inputsInbound 0, pixelValue 0, frameDone 0, activeCount 0, in the same cycle, from any state.
REQ-027 After reset, pixelInReady SHALL be 1 in the first cycle following reset deassertion.
REQ-028 Reset during LOAD or STREAM SHALL discard the partial frame; frameDone SHALL NOT pulse for it. Buffer contents need not be cleared.

Configuration
REQ-029 Macro ACTIVE_PIXEL_COUNT_EN defined: a 10-bit running counter SHALL add each bit streamed as 1 during STREAM; on the STREAM->LOAD edge activeCount SHALL load the final total and hold it until the next frame completes or reset.
REQ-030 Macro ACTIVE_PIXEL_COUNT_EN undefined: the counter and port activeCount SHALL not exist; all other behaviour is identical.

Verification
REQ-031 Reset, then 784 pixels of value 200 with valid held high -> WAIT after 784 accepts; readyForInputs=1 -> 784 consecutive cycles inputsInbound=1, pixelValue=1; frameDone single pulse; activeCount=784 (if enabled).
REQ-032 Pixels alternating 127,128 with THRESHOLD=128 -> streamed pattern 0,1,0,1...; activeCount=392.
REQ-033 pixelInValid toggled randomly with 50% duty during LOAD -> streamed bits match accepted pixels in order with no loss or duplication.
REQ-034 Frame loaded, readyForInputs held 0 for 100 cycles -> stays in WAIT, pixelInReady=0, inputsInbound=0; raise to 1 -> STREAM starts next cycle; drop to 0 mid-stream -> stream still completes 784 cycles.
REQ-035 reset asserted at STREAM cycle 400 -> inputsInbound=0 next cycle, no frameDone, pixelInReady=1 after release, next full frame streams correctly.
